// File: rtl/spi_slave_pkg.sv
// SPI memory slave shared definitions.
// State encoding and counter sizing helper.
package spi_slave_pkg;

  typedef enum logic [3:0] {
    GET_ADDR     = 4'd0,
    GOT          = 4'd1,
    READ_WAIT    = 4'd2,
    READ_LOAD    = 4'd3,
    READ_SHIFT   = 4'd4,
    WRITE_SHIFT  = 4'd5,
    WRITE_COMMIT = 4'd6,
    BURST_NEXT   = 4'd7,
    DONE         = 4'd8
  } state_e;

  // Width able to hold max(h, d) with one spare bit.
  function automatic int cnt_width(input int h, input int d);
    int m;
    m = (h > d) ? h : d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// SPI slave bit counter.
// Counts enabled pulses, wraps to 0 on the terminal count.
module spi_bit_counter #(
  parameter int W = 4
) (
  input  logic         s_clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign done = en && (count_q == limit);

  // Next count: clear, wrap on terminal pulse, or step.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (done) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge s_clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI memory slave control FSM.
// Header, then read/write data words, optional burst.
module spi_slave_ctrl #(
  parameter int ADDR_BITS = 7,
  parameter int DATA_BITS = 8,
  parameter int BURST_EN  = 1
) (
  input  logic s_clk,
  input  logic reset,
  input  logic cs,
  input  logic sclk_pos,
  input  logic sclk_neg,
  input  logic read_write,
  output logic miso_buff,
  output logic dm_we,
  output logic ad_we,
  output logic sr_we,
  output logic addr_inc,
  output logic busy
);

  import spi_slave_pkg::*;

  localparam int H  = ADDR_BITS + 1;
  localparam int CW = cnt_width(H, DATA_BITS);

  localparam logic [CW-1:0] HDR_LAST = CW'(H - 1);
  localparam logic [CW-1:0] DAT_LAST = CW'(DATA_BITS - 1);

  state_e state_q;
  state_e state_d;
  logic   dir_q;
  logic   dir_d;

  logic          neg_only;
  logic          cnt_en;
  logic [CW-1:0] cnt_limit;
  logic          cnt_done;

  // A falling edge coincident with a rising edge is dropped.
  assign neg_only = sclk_neg & ~sclk_pos;

  // Which edge the counter follows and where it stops.
  always_comb begin
    cnt_en    = 1'b0;
    cnt_limit = DAT_LAST;
    unique case (state_q)
      GET_ADDR: begin
        cnt_en    = sclk_pos;
        cnt_limit = HDR_LAST;
      end
      WRITE_SHIFT: cnt_en = sclk_pos;
      READ_SHIFT:  cnt_en = neg_only;
      default: ;
    endcase
  end

  spi_bit_counter #(
    .W(CW)
  ) u_cnt (
    .s_clk (s_clk),
    .reset (reset),
    .clr   (cs),
    .en    (cnt_en),
    .limit (cnt_limit),
    .done  (cnt_done)
  );

  // Next state and latched direction.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    unique case (state_q)
      GET_ADDR: begin
        if (cnt_done) state_d = GOT;
      end
      GOT: begin
        dir_d   = read_write;
        state_d = read_write ? READ_WAIT : WRITE_SHIFT;
      end
      READ_WAIT:  state_d = READ_LOAD;
      READ_LOAD:  state_d = READ_SHIFT;
      READ_SHIFT: begin
        if (cnt_done) begin
          state_d = (BURST_EN != 0) ? BURST_NEXT : DONE;
        end
      end
      WRITE_SHIFT: begin
        if (cnt_done) state_d = WRITE_COMMIT;
      end
      WRITE_COMMIT: begin
        state_d = (BURST_EN != 0) ? BURST_NEXT : DONE;
      end
      BURST_NEXT: begin
        state_d = dir_q ? READ_WAIT : WRITE_SHIFT;
      end
      DONE:    state_d = DONE;
      default: state_d = GET_ADDR;
    endcase
    if (cs) begin
      state_d = GET_ADDR;
    end
  end

  // State and direction registers.
  always_ff @(posedge s_clk) begin
    if (reset) begin
      state_q <= GET_ADDR;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
    end
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    miso_buff = 1'b0;
    dm_we     = 1'b0;
    ad_we     = 1'b0;
    sr_we     = 1'b0;
    addr_inc  = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      GET_ADDR:     busy      = 1'b0;
      GOT:          ad_we     = 1'b1;
      READ_LOAD:    sr_we     = 1'b1;
      READ_SHIFT:   miso_buff = 1'b1;
      WRITE_COMMIT: dm_we     = 1'b1;
      BURST_NEXT:   addr_inc  = 1'b1;
      DONE:         busy      = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Bench for spi_slave_ctrl: three configurations.
// Expected events are queued by stimulus, checked by monitor.
module tb_spi_slave_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       sclk_pos;
  logic       sclk_neg;
  logic       read_write;
  logic [2:0] csv;
  logic [2:0] miso_w, dm_w, ad_w, sr_w, inc_w, busy_w;

  int   sel;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  bit   done_req;
  bit   done_ack;
  logic prev_miso;

  // vector order: {busy, miso, dm, ad, sr, inc}
  localparam logic [5:0] V_IDLE = 6'b000000;
  localparam logic [5:0] V_AD   = 6'b100100;
  localparam logic [5:0] V_SR   = 6'b100010;
  localparam logic [5:0] V_DM   = 6'b101000;
  localparam logic [5:0] V_INC  = 6'b100001;
  localparam logic [5:0] V_MISO = 6'b110000;
  localparam logic [5:0] V_BUSY = 6'b100000;

  typedef struct {
    string      name;
    int         cyc;
    logic [5:0] v;
    bit         probe;
  } exp_t;

  exp_t q[$];

  spi_slave_ctrl #(
    .ADDR_BITS(7), .DATA_BITS(8), .BURST_EN(0)
  ) u0 (
    .s_clk(clk), .reset(reset), .cs(csv[0]),
    .sclk_pos(sclk_pos), .sclk_neg(sclk_neg),
    .read_write(read_write),
    .miso_buff(miso_w[0]), .dm_we(dm_w[0]),
    .ad_we(ad_w[0]), .sr_we(sr_w[0]),
    .addr_inc(inc_w[0]), .busy(busy_w[0])
  );

  spi_slave_ctrl u1 (
    .s_clk(clk), .reset(reset), .cs(csv[1]),
    .sclk_pos(sclk_pos), .sclk_neg(sclk_neg),
    .read_write(read_write),
    .miso_buff(miso_w[1]), .dm_we(dm_w[1]),
    .ad_we(ad_w[1]), .sr_we(sr_w[1]),
    .addr_inc(inc_w[1]), .busy(busy_w[1])
  );

  spi_slave_ctrl #(
    .ADDR_BITS(15), .DATA_BITS(16), .BURST_EN(0)
  ) u2 (
    .s_clk(clk), .reset(reset), .cs(csv[2]),
    .sclk_pos(sclk_pos), .sclk_neg(sclk_neg),
    .read_write(read_write),
    .miso_buff(miso_w[2]), .dm_we(dm_w[2]),
    .ad_we(ad_w[2]), .sr_we(sr_w[2]),
    .addr_inc(inc_w[2]), .busy(busy_w[2])
  );

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any pulse, a miso edge, or a due probe pops one entry.
  logic [5:0] mv;
  bit         trig;
  exp_t       me;
  initial begin
    n_cmp = 0;
    n_bad = 0;
    prev_miso = 1'b0;
    done_ack = 1'b0;
  end
  always @(negedge clk) begin
    mv = {busy_w[sel], miso_w[sel], dm_w[sel],
          ad_w[sel], sr_w[sel], inc_w[sel]};
    trig = (mv[3:0] != 4'b0) || (mv[4] != prev_miso);
    if (q.size() > 0 && q[0].probe && q[0].cyc == cyc)
      trig = 1'b1;
    prev_miso = mv[4];
    if (trig) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected cyc=%0d dut=%0d act=%b req=none",
                 cyc, sel, mv);
      end else begin
        me = q.pop_front();
        if (me.cyc != cyc || me.v != mv) begin
          n_bad++;
          $display("FAIL %s act cyc=%0d vec=%b req cyc=%0d vec=%b",
                   me.name, cyc, mv, me.cyc, me.v);
        end
      end
    end
    if (done_req && !done_ack) begin
      n_cmp++;
      if (q.size() != 0) begin
        n_bad++;
        $display("FAIL leftover act=%0d req=0 next=%s",
                 q.size(), q[0].name);
      end
      done_ack = 1'b1;
    end
  end

  task automatic push(string nm, int c, logic [5:0] v, bit p);
    exp_t e;
    e.name  = nm;
    e.cyc   = c;
    e.v     = v;
    e.probe = p;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(int k);
    repeat (k) tick();
  endtask

  // k one-cycle pulses, 4 s_clk apart; n = cycle after last sample.
  task automatic pulses(bit neg, int k, output int n);
    n = 0;
    for (int i = 0; i < k; i++) begin
      if (i > 0) gap(3);
      if (neg) sclk_neg = 1'b1;
      else     sclk_pos = 1'b1;
      tick();
      sclk_pos = 1'b0;
      sclk_neg = 1'b0;
      n = cyc;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1);
  end

  initial begin
    int n;
    sel        = 0;
    done_req   = 1'b0;
    reset      = 1'b1;
    csv        = 3'b111;
    sclk_pos   = 1'b0;
    sclk_neg   = 1'b0;
    read_write = 1'b0;
    tick();
    push("reset_idle", cyc, V_IDLE, 1'b1);
    tick();
    reset = 1'b0;

    // single write, no burst
    csv[0] = 1'b0;
    tick();
    read_write = 1'b0;
    pulses(1'b0, 8, n);
    push("w_ad", n, V_AD, 1'b0);
    gap(3);
    pulses(1'b0, 8, n);
    push("w_dm", n, V_DM, 1'b0);
    push("w_done", n + 1, V_IDLE, 1'b1);
    gap(3);
    csv[0] = 1'b1;
    tick();

    // single read with a coincident edge pair mid-word
    csv[0] = 1'b0;
    tick();
    read_write = 1'b1;
    pulses(1'b0, 8, n);
    push("r_ad", n, V_AD, 1'b0);
    push("r_sr", n + 2, V_SR, 1'b0);
    push("r_miso_on", n + 3, V_MISO, 1'b0);
    gap(3);
    pulses(1'b1, 4, n);
    gap(3);
    sclk_pos = 1'b1;
    sclk_neg = 1'b1;
    tick();
    sclk_pos = 1'b0;
    sclk_neg = 1'b0;
    gap(3);
    pulses(1'b1, 4, n);
    push("r_miso_off", n, V_IDLE, 1'b0);
    gap(3);
    csv[0] = 1'b1;
    tick();

    // abort a write after 5 data bits
    csv[0] = 1'b0;
    tick();
    read_write = 1'b0;
    pulses(1'b0, 8, n);
    push("ab_ad", n, V_AD, 1'b0);
    gap(3);
    pulses(1'b0, 5, n);
    gap(3);
    csv[0] = 1'b1;
    tick();
    push("ab_idle", cyc, V_IDLE, 1'b1);
    csv[0] = 1'b0;
    tick();
    pulses(1'b0, 7, n);
    gap(3);
    pulses(1'b0, 1, n);
    push("ab_hdr2", n, V_AD, 1'b0);
    gap(3);
    csv[0] = 1'b1;
    tick();

    // reset in the middle of a read word
    csv[0] = 1'b0;
    tick();
    read_write = 1'b1;
    pulses(1'b0, 8, n);
    push("rr_ad", n, V_AD, 1'b0);
    push("rr_sr", n + 2, V_SR, 1'b0);
    push("rr_miso_on", n + 3, V_MISO, 1'b0);
    gap(3);
    pulses(1'b1, 3, n);
    gap(3);
    reset = 1'b1;
    tick();
    push("rr_reset", cyc, V_IDLE, 1'b0);
    reset = 1'b0;
    tick();
    read_write = 1'b0;
    pulses(1'b0, 8, n);
    push("rr_ad2", n, V_AD, 1'b0);
    gap(3);
    pulses(1'b0, 8, n);
    push("rr_dm", n, V_DM, 1'b0);
    push("rr_done", n + 1, V_IDLE, 1'b1);
    gap(3);
    csv[0] = 1'b1;
    tick();

    // burst write, three words
    sel    = 1;
    csv[1] = 1'b0;
    tick();
    read_write = 1'b0;
    pulses(1'b0, 8, n);
    push("b_ad", n, V_AD, 1'b0);
    gap(3);
    for (int w = 0; w < 3; w++) begin
      pulses(1'b0, 8, n);
      push($sformatf("b_dm%0d", w), n, V_DM, 1'b0);
      push($sformatf("b_inc%0d", w), n + 1, V_INC, 1'b0);
      gap(3);
    end
    push("b_hold", cyc, V_BUSY, 1'b1);
    csv[1] = 1'b1;
    tick();
    push("b_cs_idle", cyc, V_IDLE, 1'b1);
    tick();

    // wide header and data
    sel    = 2;
    csv[2] = 1'b0;
    tick();
    read_write = 1'b0;
    pulses(1'b0, 16, n);
    push("x_ad", n, V_AD, 1'b0);
    gap(3);
    pulses(1'b0, 16, n);
    push("x_dm", n, V_DM, 1'b0);
    push("x_done", n + 1, V_IDLE, 1'b1);
    gap(3);
    csv[2] = 1'b1;
    tick();
    gap(2);

    done_req = 1'b1;
    for (int i = 0; i < 4 && !done_ack; i++) @(posedge clk);
    if (!done_ack) begin
      $display("FAIL end_handshake act=0 req=1");
      $fatal(1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
